// File: rtl/fetch_pc_if.sv
// fetch_pc_if: fetch-stage redirect sources and PC/flush results between pipeline and fetch_pc_ctrl
interface fetch_pc_if #(
  parameter int XLEN      = 32,
  parameter int CNT_WIDTH = 16
);
  logic            stall;
  logic            btb_hit, if_branch, if_jump, if_ret;
  logic [1:0]      if_pred;
  logic [XLEN-1:0] if_target;
  logic            id_branch, id_jal, id_call, id_btb_hit;
  logic [1:0]      id_pred;
  logic [XLEN-1:0] id_target, id_pc4;
  logic            ex_branch, ex_mispredict, ex_taken, ex_jalr;
  logic [XLEN-1:0] ex_target, ex_pc4, ex_jalr_target;
  logic [XLEN-1:0] pc, next_pc;
  logic            id_flush, ex_flush, ras_empty;
  logic [CNT_WIDTH-1:0] mispredict_cnt;
  modport master (
    output stall, btb_hit, if_branch, if_jump, if_ret, if_pred, if_target,
           id_branch, id_jal, id_call, id_btb_hit, id_pred, id_target, id_pc4,
           ex_branch, ex_mispredict, ex_taken, ex_jalr, ex_target, ex_pc4, ex_jalr_target,
    input  pc, next_pc, id_flush, ex_flush, ras_empty, mispredict_cnt
  );
  modport slave (
    input  stall, btb_hit, if_branch, if_jump, if_ret, if_pred, if_target,
           id_branch, id_jal, id_call, id_btb_hit, id_pred, id_target, id_pc4,
           ex_branch, ex_mispredict, ex_taken, ex_jalr, ex_target, ex_pc4, ex_jalr_target,
    output pc, next_pc, id_flush, ex_flush, ras_empty, mispredict_cnt
  );
endinterface

// File: rtl/fetch_pc_ctrl.sv
// fetch_pc_ctrl: next-PC arbitration (EX > ID > BTB > RAS > pc+4), PC register, flushes, mispredict counter.
// Define FETCH_RAS_EN to enable the return-address stack; otherwise returns fall through to pc+4.
module fetch_pc_ctrl #(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter int              RAS_DEPTH    = 4,
  parameter int              CNT_WIDTH    = 16
) (
  input logic clk,
  input logic rst,
  fetch_pc_if.slave bus
);
  localparam int PW = $clog2(RAS_DEPTH);
  logic [XLEN-1:0]      pc_q, pc_d, ras_top;
  logic [CNT_WIDTH-1:0] cnt_q;
  logic ex_jalr_r, ex_mis_r, id_redir, if_redir, ras_hit, redirect, ex_flush, ras_empty;
  assign ex_jalr_r = bus.ex_jalr;
  assign ex_mis_r  = bus.ex_branch & bus.ex_mispredict;
  assign id_redir  = !bus.id_btb_hit & ((bus.id_branch & bus.id_pred[1]) | bus.id_jal);
  assign if_redir  = bus.btb_hit & (bus.if_jump | (bus.if_branch & bus.if_pred[1]));
  assign redirect  = ex_jalr_r | ex_mis_r | id_redir;
  assign ex_flush  = !rst & (ex_jalr_r | (ex_mis_r & bus.ex_taken));
  always_comb
    pc_d = ex_jalr_r ? {bus.ex_jalr_target[XLEN-1:1], 1'b0} :
           ex_mis_r  ? (bus.ex_taken ? bus.ex_target : bus.ex_pc4) :
           id_redir  ? bus.id_target :
           if_redir  ? bus.if_target :
           ras_hit   ? ras_top : pc_q + XLEN'(4);
  always_ff @(posedge clk)
    if (rst) begin
      pc_q  <= RESET_VECTOR;
      cnt_q <= '0;
    end else begin
      if (!bus.stall || redirect) pc_q <= pc_d;
      if ((ex_jalr_r || ex_mis_r) && cnt_q != '1) cnt_q <= cnt_q + CNT_WIDTH'(1);
    end
`ifdef FETCH_RAS_EN
  logic [XLEN-1:0] ras_q [RAS_DEPTH];
  logic [PW-1:0]   ptr_q;
  logic [PW:0]     num_q;
  logic            push, pop;
  assign ras_empty = num_q == '0;
  assign ras_top   = ras_q[ptr_q - PW'(1)];
  assign ras_hit   = bus.if_ret & !ras_empty;
  assign push      = bus.id_call & !ex_flush & !bus.stall;
  assign pop       = ras_hit & !redirect & !if_redir & !bus.stall;
  // ptr_q points at the next free slot; a full push wraps and overwrites the oldest entry
  always_ff @(posedge clk)
    if (rst) begin
      ptr_q <= '0;
      num_q <= '0;
    end else if (push && pop) begin
      ras_q[ptr_q - PW'(1)] <= bus.id_pc4;
    end else if (push) begin
      ras_q[ptr_q] <= bus.id_pc4;
      ptr_q        <= ptr_q + PW'(1);
      num_q        <= (num_q == (PW+1)'(RAS_DEPTH)) ? num_q : num_q + (PW+1)'(1);
    end else if (pop) begin
      ptr_q <= ptr_q - PW'(1);
      num_q <= num_q - (PW+1)'(1);
    end
`else
  logic unused_ras;
  assign ras_empty  = 1'b1;
  assign ras_hit    = 1'b0;
  assign ras_top    = '0;
  assign unused_ras = ^{bus.if_ret, bus.id_call, bus.id_pc4};
`endif
  assign bus.pc             = pc_q;
  assign bus.next_pc        = pc_d;
  assign bus.id_flush       = !rst & redirect;
  assign bus.ex_flush       = ex_flush;
  assign bus.ras_empty      = ras_empty;
  assign bus.mispredict_cnt = cnt_q;
endmodule

// File: tb/tb_fetch_pc_ctrl.sv
// tb_fetch_pc_ctrl: directed checks of reset, redirect priority, stall, flushes, counter saturation, wrap and RAS.
module tb_fetch_pc_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk = 0;
  int   n_fail = 0;
  fetch_pc_if #(.XLEN(32), .CNT_WIDTH(2)) bus ();
  fetch_pc_ctrl #(.XLEN(32), .RESET_VECTOR(32'h100), .RAS_DEPTH(4), .CNT_WIDTH(2)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic clear();
    bus.stall = 0; bus.btb_hit = 0; bus.if_branch = 0; bus.if_jump = 0; bus.if_ret = 0;
    bus.if_pred = 2'b00; bus.if_target = '0;
    bus.id_branch = 0; bus.id_jal = 0; bus.id_call = 0; bus.id_btb_hit = 0;
    bus.id_pred = 2'b00; bus.id_target = '0; bus.id_pc4 = '0;
    bus.ex_branch = 0; bus.ex_mispredict = 0; bus.ex_taken = 0; bus.ex_jalr = 0;
    bus.ex_target = '0; bus.ex_pc4 = '0; bus.ex_jalr_target = '0;
  endtask
  initial begin
    clear();
    bus.ex_jalr = 1; bus.ex_jalr_target = 32'h777;
    tick(); tick();
    chk("rst_pc", bus.pc, 32'h100);
    chk("rst_cnt", 32'(bus.mispredict_cnt), 32'd0);
    chk("rst_ras_empty", 32'(bus.ras_empty), 32'd1);
    chk("rst_id_flush", 32'(bus.id_flush), 32'd0);
    chk("rst_ex_flush", 32'(bus.ex_flush), 32'd0);
    clear(); rst = 0;
    tick();
    chk("first_inc", bus.pc, 32'h104);
    bus.btb_hit = 1; bus.if_branch = 1; bus.if_pred = 2'b10; bus.if_target = 32'h200; #1;
    chk("btb_taken_next", bus.next_pc, 32'h200);
    chk("btb_no_id_flush", 32'(bus.id_flush), 32'd0);
    chk("btb_no_ex_flush", 32'(bus.ex_flush), 32'd0);
    tick();
    chk("btb_taken_pc", bus.pc, 32'h200);
    bus.if_pred = 2'b01; #1;
    chk("btb_nt_next", bus.next_pc, 32'h204);
    tick();
    chk("btb_nt_pc", bus.pc, 32'h204);
    bus.btb_hit = 0; bus.if_branch = 0; bus.if_jump = 1;
    tick();
    chk("jump_no_hit", bus.pc, 32'h208);
    clear(); bus.stall = 1;
    tick();
    chk("stall_hold", bus.pc, 32'h208);
    bus.id_jal = 1; bus.id_target = 32'h500;
    bus.ex_branch = 1; bus.ex_mispredict = 1; bus.ex_taken = 0; bus.ex_pc4 = 32'h48; #1;
    chk("exmis_next", bus.next_pc, 32'h48);
    chk("exmis_id_flush", 32'(bus.id_flush), 32'd1);
    chk("exmis_ex_flush", 32'(bus.ex_flush), 32'd0);
    tick();
    chk("exmis_pc", bus.pc, 32'h48);
    chk("exmis_cnt", 32'(bus.mispredict_cnt), 32'd1);
    bus.ex_branch = 0; bus.ex_mispredict = 0; #1;
    chk("idjal_next", bus.next_pc, 32'h500);
    chk("idjal_id_flush", 32'(bus.id_flush), 32'd1);
    chk("idjal_ex_flush", 32'(bus.ex_flush), 32'd0);
    tick();
    chk("idjal_over_stall", bus.pc, 32'h500);
    chk("idjal_cnt", 32'(bus.mispredict_cnt), 32'd1);
    bus.stall = 0; bus.id_btb_hit = 1; #1;
    chk("idbtb_next", bus.next_pc, 32'h504);
    chk("idbtb_no_flush", 32'(bus.id_flush), 32'd0);
    tick();
    clear();
    bus.ex_branch = 1; bus.ex_mispredict = 1; bus.ex_taken = 1; bus.ex_target = 32'h600; #1;
    chk("extaken_ex_flush", 32'(bus.ex_flush), 32'd1);
    tick();
    chk("extaken_pc", bus.pc, 32'h600);
    chk("extaken_cnt", 32'(bus.mispredict_cnt), 32'd2);
    clear();
    bus.ex_jalr = 1; bus.ex_jalr_target = 32'h301;
    bus.btb_hit = 1; bus.if_jump = 1; bus.if_target = 32'h900; #1;
    chk("jalr_next", bus.next_pc, 32'h300);
    chk("jalr_id_flush", 32'(bus.id_flush), 32'd1);
    chk("jalr_ex_flush", 32'(bus.ex_flush), 32'd1);
    tick();
    chk("jalr_pc", bus.pc, 32'h300);
    chk("jalr_cnt", 32'(bus.mispredict_cnt), 32'd3);
    clear();
    bus.ex_branch = 1; bus.ex_mispredict = 1; bus.ex_pc4 = 32'h80;
    tick();
    chk("sat_pc", bus.pc, 32'h80);
    chk("sat_cnt", 32'(bus.mispredict_cnt), 32'd3);
    clear();
    bus.ex_jalr = 1; bus.ex_jalr_target = 32'hFFFF_FFFD;
    tick();
    chk("wrap_top", bus.pc, 32'hFFFF_FFFC);
    chk("sat_hold", 32'(bus.mispredict_cnt), 32'd3);
    clear();
    tick();
    chk("wrap_zero", bus.pc, 32'h0);
`ifdef FETCH_RAS_EN
    for (int i = 1; i <= 5; i++) begin
      bus.id_call = 1; bus.id_pc4 = 32'(i * 16);
      tick();
    end
    clear();
    chk("ras_pushed_pc", bus.pc, 32'h14);
    chk("ras_not_empty", 32'(bus.ras_empty), 32'd0);
    bus.if_ret = 1; bus.stall = 1;
    tick();
    chk("ras_stall_pc", bus.pc, 32'h14);
    bus.stall = 0;
    for (int i = 5; i >= 2; i--) begin
      #1;
      chk("ras_pred_next", bus.next_pc, 32'(i * 16));
      tick();
      chk("ras_pred_pc", bus.pc, 32'(i * 16));
    end
    #1;
    chk("ras_drained_empty", 32'(bus.ras_empty), 32'd1);
    chk("ras_drained_next", bus.next_pc, 32'h24);
`else
    bus.id_call = 1; bus.id_pc4 = 32'h10;
    tick();
    bus.id_call = 0; bus.if_ret = 1; #1;
    chk("noras_empty", 32'(bus.ras_empty), 32'd1);
    chk("noras_next", bus.next_pc, 32'h8);
    tick();
    chk("noras_pc", bus.pc, 32'h8);
`endif
    clear();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/fetch_pc_ctrl.md
Name: fetch_pc_ctrl

Overview:
Parametrised next-PC generator and PC register for the fetch stage. It arbitrates redirects from three sources, in this order: EX resolution, ID-stage decode prediction, and IF-stage BTB prediction. It holds the architectural fetch PC under stall and drives the ID and EX flush pulses. New relative to the current next-PC logic: an internal PC register with reset vector, stall handling, a return-address stack (RAS), and a saturating mispredict counter.

Parameters:
XLEN, 32, PC/address width
RESET_VECTOR, 32'h0000_0000, PC value loaded on reset
RAS_DEPTH, 4, return-address stack entries (power of two, >=2)
CNT_WIDTH, 16, width of mispredict counter

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
stall  in  1  hold PC (hazard unit)
btb_hit  in  1  BTB hit for current IF PC
if_branch, if_jump, if_ret  in  1 each  IF predecode class; if_ret = JALR x0,0(ra)
if_pred  in  2  IF 2-bit counter
if_target  in  XLEN  BTB target
id_branch, id_jal, id_call  in  1 each  ID decode; id_call = JAL/JALR with rd=x1/x5
id_pred  in  2  ID 2-bit counter
id_target  in  XLEN  ID pc+imm
id_pc4  in  XLEN  ID pc+4 (RAS push value)
id_btb_hit  in  1  instruction in ID hit BTB in IF
ex_branch  in  1  branch in EX
ex_mispredict  in  1  branch outcome differs from prediction
ex_taken  in  1  actual outcome
ex_target, ex_pc4  in  XLEN  EX pc+imm, pc+4
ex_jalr  in  1  JALR in EX (excluding RAS-predicted returns that matched)
ex_jalr_target  in  XLEN  rs1+imm
pc  out  XLEN  current fetch PC (registered)
next_pc  out  XLEN  combinational next PC
id_flush, ex_flush  out  1 each  flush pulses
ras_empty  out  1  RAS has no entries
mispredict_cnt  out  CNT_WIDTH  EX redirect count

Behaviour:
- Reset (rst high at clk edge): pc=RESET_VECTOR, RAS count=0, pointer=0, mispredict_cnt=0. rst overrides every other input. id_flush/ex_flush are combinational and are 0 while rst is high.
- Predicted taken: counter MSB==1 (2'b10, 2'b11).
- next_pc priority, highest first:
  1. EX jalr: ex_jalr_target with bit0 cleared; id_flush=ex_flush=1.
  2. EX mispredict: ex_taken ? ex_target : ex_pc4; id_flush=1; ex_flush=ex_taken.
  3. ID redirect when !id_btb_hit: (id_branch & id_pred MSB) or id_jal -> id_target; id_flush=1.
  4. IF with btb_hit: if_jump, or (if_branch & if_pred MSB) -> if_target.
  5. IF if_ret & !ras_empty (RAS enabled): next_pc = RAS top.
  6. Otherwise: pc+4, modulo 2^XLEN wrap.
- pc update: at every clk edge, pc<=next_pc unless stall=1 and no EX/ID redirect is active. Redirects (1–3) override stall. Latency is one cycle from redirect to pc.
- mispredict_cnt increments on each cycle where case 1 or 2 fires. It saturates at all-ones.
- RAS push: id_call & !ex_flush & !stall pushes id_pc4.
- RAS pop: IF case 5 taken & !stall. Only IF-stage pops; EX does not restore the RAS.
- Push when full: overwrite oldest entry (circular pointer wrap); count stays RAS_DEPTH.
- Pop when empty: not taken (ras_empty=1); pc+4 is used.
- Simultaneous push and pop: top replaced by the push value; count unchanged.
- RAS contents are not repaired on flush. Wrong-path pops therefore cost an EX jalr redirect.

Optional Feature:
FETCH_RAS_EN defined: RAS storage, case 5, and ras_empty behave as above.
Undefined: no RAS storage; case 5 is removed; ras_empty tied 1; returns fall through to pc+4 and are corrected by EX jalr.

Test Plan:
- Reset: rst=1 for 2 cycles with RESET_VECTOR=32'h100 -> pc=0x100, mispredict_cnt=0, ras_empty=1; next cycle pc=0x104.
- BTB-hit taken branch: btb_hit=1, if_branch=1, if_pred=2'b10, if_target=0x200 -> pc=0x200 next cycle, no flush. Repeat with if_pred=2'b01 -> pc+4.
- EX mispredict during stall and ID redirect: stall=1, id_jal=1, ex_branch=1, ex_mispredict=1, ex_taken=0, ex_pc4=0x48 -> next_pc=0x48, id_flush=1, ex_flush=0, counter +1.
- JALR alignment: ex_jalr=1, ex_jalr_target=0x301 -> pc=0x300, both flushes asserted.
- RAS (FETCH_RAS_EN, depth 4): five calls pushing 0x10,0x20,0x30,0x40,0x50, then five if_ret -> predictions 0x50,0x40,0x30,0x20, then pc+4 with ras_empty=1.
- Counter saturation with CNT_WIDTH=2: four EX mispredicts -> mispredict_cnt=2'b11 and holds.
